gcm_aes_dec_verify: RTL and testbench

Receive-side counterpart of gcm_aes. It takes AAD and ciphertext blocks, XORs each ciphertext block with a keystream block from an external AES-CTR engine to recover plaintext, and computes GHASH serially over AAD, ciphertext and the length block. At the end it compares S xor E(K,J0) against the received tag and reports authentication pass or fail. The hash key H and E(K,J0) come from the shared key-schedule/AES core.

---
 rtl/gcm_aes_dec_verify.sv | 164 ++++++++++++++++
 tb/tb_gcm_aes_dec_verify.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_aes_dec_verify.sv
// gcm_aes_dec_verify: GCM receive path with CTR decrypt, digit-serial GHASH and tag verification.
// Define GCM_DEC_TAG_TRUNC_EN to add i_tag_bits and compare a truncated tag.
module gcm_aes_dec_verify #(
    parameter int DIGIT_BITS = 1
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [0:127] i_hash_key,
    input  logic [0:127] i_ek_j0,
    input  logic [0:63]  i_aad_size,
    input  logic [0:63]  i_ct_size,
    input  logic [0:127] i_aad,
    input  logic         i_aad_valid,
    output logic         o_aad_ready,
    input  logic [0:127] i_cipher_text,
    input  logic [0:127] i_keystream,
    input  logic         i_ct_valid,
    output logic         o_ct_ready,
    output logic [0:127] o_plain_text,
    output logic         o_pt_valid,
    input  logic [0:127] i_tag,
    input  logic         i_tag_valid,
    output logic         o_tag_ready,
`ifdef GCM_DEC_TAG_TRUNC_EN
    input  logic [0:7]   i_tag_bits,
`endif
    output logic         o_busy,
    output logic         o_done,
    output logic         o_auth_ok,
    output logic         o_auth_fail
);
    localparam int M = 128 / DIGIT_BITS;
    localparam logic [7:0] M_LAST = 8'(M - 1);
    localparam logic [0:127] R = {8'he1, 120'd0};
    localparam logic [0:127] ONES = '1;

    typedef enum logic [3:0] {IDLE, AAD, MUL_A, CT, MUL_C, LEN, MUL_L, TAG, DONE} state_t;
    state_t state;

    logic [0:127] h, ek0, s, x, z, v, zn, vn;
    logic [0:127] aad_keep, ct_keep, tag_keep;
    logic [0:63]  aad_size, ct_size;
    logic [57:0]  aad_left, ct_left, na_in, nc_in;
    logic [7:0]   cnt;
    logic         mul, tag_legal, tag_match;

    assign na_in = {1'b0, i_aad_size[0:56]} + {57'd0, |i_aad_size[57:63]};
    assign nc_in = {1'b0, i_ct_size[0:56]} + {57'd0, |i_ct_size[57:63]};
    // Only the final block of a stream can be partial; earlier blocks pass whole.
    assign aad_keep = (aad_left == 58'd1 && aad_size[57:63] != 7'd0) ? ~(ONES >> aad_size[57:63]) : ONES;
    assign ct_keep = (ct_left == 58'd1 && ct_size[57:63] != 7'd0) ? ~(ONES >> ct_size[57:63]) : ONES;

`ifdef GCM_DEC_TAG_TRUNC_EN
    logic [0:7] tag_bits;
    assign tag_legal = tag_bits inside {8'd96, 8'd104, 8'd112, 8'd120, 8'd128};
    assign tag_keep = ~(ONES >> tag_bits);
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            tag_bits <= '0;
        else if (i_start && !o_busy)
            tag_bits <= i_tag_bits;
    end
`else
    assign tag_legal = 1'b1;
    assign tag_keep = ONES;
`endif

    assign tag_match = tag_legal && (((s ^ ek0 ^ i_tag) & tag_keep) == '0);
    assign mul = state inside {MUL_A, MUL_C, MUL_L};
    assign o_busy = !(state inside {IDLE, DONE});
    assign o_aad_ready = state == AAD;
    assign o_ct_ready = state == CT;
    assign o_tag_ready = state == TAG;

    // Reflected GF(2^128) multiply, DIGIT_BITS bits of x per cycle, v walks H*x^i.
    always_comb begin
        zn = z;
        vn = v;
        for (int j = 0; j < DIGIT_BITS; j++) begin
            zn = x[j] ? zn ^ vn : zn;
            vn = vn[127] ? (vn >> 1) ^ R : vn >> 1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            h <= '0;
            ek0 <= '0;
            aad_size <= '0;
            ct_size <= '0;
            aad_left <= '0;
            ct_left <= '0;
            s <= '0;
            x <= '0;
            z <= '0;
            v <= '0;
            cnt <= '0;
            o_plain_text <= '0;
            o_pt_valid <= 1'b0;
            o_done <= 1'b0;
            o_auth_ok <= 1'b0;
            o_auth_fail <= 1'b0;
        end else begin
            o_pt_valid <= 1'b0;
            o_done <= 1'b0;
            if (!mul) begin
                z <= '0;
                v <= h;
                cnt <= '0;
            end
            case (state)
                IDLE, DONE: if (i_start) begin
                    h <= i_hash_key;
                    ek0 <= i_ek_j0;
                    aad_size <= i_aad_size;
                    ct_size <= i_ct_size;
                    aad_left <= na_in;
                    ct_left <= nc_in;
                    s <= '0;
                    o_auth_ok <= 1'b0;
                    o_auth_fail <= 1'b0;
                    state <= (na_in != 58'd0) ? AAD : (nc_in != 58'd0) ? CT : LEN;
                end
                AAD: if (i_aad_valid) begin
                    x <= s ^ (i_aad & aad_keep);
                    aad_left <= aad_left - 58'd1;
                    state <= MUL_A;
                end
                CT: if (i_ct_valid) begin
                    x <= s ^ (i_cipher_text & ct_keep);
                    o_plain_text <= (i_cipher_text ^ i_keystream) & ct_keep;
                    o_pt_valid <= 1'b1;
                    ct_left <= ct_left - 58'd1;
                    state <= MUL_C;
                end
                LEN: begin
                    x <= s ^ {aad_size, ct_size};
                    state <= MUL_L;
                end
                MUL_A, MUL_C, MUL_L: begin
                    z <= zn;
                    v <= vn;
                    x <= x << DIGIT_BITS;
                    cnt <= cnt + 8'd1;
                    if (cnt == M_LAST) begin
                        s <= zn;
                        state <= (state == MUL_L) ? TAG :
                                 (state == MUL_A && aad_left != 58'd0) ? AAD :
                                 (ct_left != 58'd0) ? CT : LEN;
                    end
                end
                TAG: if (i_tag_valid) begin
                    o_done <= 1'b1;
                    o_auth_ok <= tag_match;
                    o_auth_fail <= !tag_match;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcm_aes_dec_verify.sv
// tb_gcm_aes_dec_verify: table-driven bench with plaintext/verdict scoreboards and a polynomial GHASH model.
module tb_gcm_aes_dec_verify;
    localparam int M = 128;
    localparam int BUDGET = 4 * M;
    localparam logic [0:127] H0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [0:127] E0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [0:127] C1 = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [0:127] T1 = 128'hab6e47d42cec13bdf53a67b21257bddf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         i_rst_n, i_start, i_aad_valid, i_ct_valid, i_tag_valid;
    logic [0:127] i_hash_key, i_ek_j0, i_aad, i_cipher_text, i_keystream, i_tag;
    logic [0:63]  i_aad_size, i_ct_size;
    logic         o_aad_ready, o_ct_ready, o_pt_valid, o_tag_ready, o_busy, o_done, o_auth_ok, o_auth_fail;
    logic [0:127] o_plain_text;
`ifdef GCM_DEC_TAG_TRUNC_EN
    logic [0:7]   tag_bits;
`endif

    gcm_aes_dec_verify #(.DIGIT_BITS(1)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_hash_key(i_hash_key), .i_ek_j0(i_ek_j0), .i_aad_size(i_aad_size), .i_ct_size(i_ct_size),
        .i_aad(i_aad), .i_aad_valid(i_aad_valid), .o_aad_ready(o_aad_ready),
        .i_cipher_text(i_cipher_text), .i_keystream(i_keystream), .i_ct_valid(i_ct_valid), .o_ct_ready(o_ct_ready),
        .o_plain_text(o_plain_text), .o_pt_valid(o_pt_valid),
        .i_tag(i_tag), .i_tag_valid(i_tag_valid), .o_tag_ready(o_tag_ready),
`ifdef GCM_DEC_TAG_TRUNC_EN
        .i_tag_bits(tag_bits),
`endif
        .o_busy(o_busy), .o_done(o_done), .o_auth_ok(o_auth_ok), .o_auth_fail(o_auth_fail)
    );

    typedef struct {
        logic [0:127] h, e;
        logic [0:63]  asz, csz;
        logic [0:127] a0, a1, c0, c1, k0, k1, tag, s_exp;
        logic [7:0]   tbits;
        logic         exp_ok, chk_s;
    } vec_t;

    int compared = 0, mismatched = 0;
    logic [0:127] pt_q[$];
    logic [1:0]   vd_q[$];
    int  aad_pending = 0, rdy_aad_cnt = 0, rdy_ct_cnt = 0;
    bit  order_viol = 1'b0;
    time t_done = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Polynomial-domain model: bit i is the coefficient of x^i, reduced by x^128+x^7+x^2+x+1.
    function automatic logic [0:127] gmul(input logic [0:127] a, input logic [0:127] b);
        logic [0:254] p = '0;
        for (int i = 0; i < 128; i++)
            if (a[i]) for (int j = 0; j < 128; j++) p[i + j] ^= b[j];
        for (int k = 254; k >= 128; k--)
            if (p[k]) begin
                p[k] = 1'b0;
                p[k - 121] ^= 1'b1;
                p[k - 126] ^= 1'b1;
                p[k - 127] ^= 1'b1;
                p[k - 128] ^= 1'b1;
            end
        return p[0:127];
    endfunction

    function automatic logic [0:127] keep(input int r);
        logic [0:127] m;
        for (int i = 0; i < 128; i++) m[i] = (r == 0) || (i < r);
        return m;
    endfunction

    function automatic int nblk(input logic [0:63] sz);
        return int'((sz + 64'd127) >> 7);
    endfunction

    function automatic logic [0:127] pick(input logic [0:127] b0, input logic [0:127] b1, input int i);
        return (i == 0) ? b0 : b1;
    endfunction

    function automatic logic [0:127] model_tag(input vec_t t);
        logic [0:127] s = '0;
        int na = nblk(t.asz);
        int nc = nblk(t.csz);
        for (int i = 0; i < na; i++)
            s = gmul(s ^ (pick(t.a0, t.a1, i) & keep(i == na - 1 ? int'(t.asz[57:63]) : 0)), t.h);
        for (int i = 0; i < nc; i++)
            s = gmul(s ^ (pick(t.c0, t.c1, i) & keep(i == nc - 1 ? int'(t.csz[57:63]) : 0)), t.h);
        s = gmul(s ^ {t.asz, t.csz}, t.h);
        return s ^ t.e;
    endfunction

    function automatic vec_t mk(input logic [0:127] h, e, input logic [0:63] asz, csz,
                                input logic [0:127] a0, a1, c0, c1, k0, k1, tag, input logic exp_ok);
        vec_t t;
        t.h = h; t.e = e; t.asz = asz; t.csz = csz;
        t.a0 = a0; t.a1 = a1; t.c0 = c0; t.c1 = c1; t.k0 = k0; t.k1 = k1;
        t.tag = tag; t.exp_ok = exp_ok; t.tbits = 8'd128; t.chk_s = 1'b0; t.s_exp = '0;
        return t;
    endfunction

    function automatic logic rdy(input int w);
        return (w == 0) ? o_aad_ready : (w == 1) ? o_ct_ready : o_tag_ready;
    endfunction

    task automatic wait_ready(input int w, output bit ok);
        int n = 0;
        while (!rdy(w) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        ok = rdy(w);
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL timeout_ready%0d: ready low for %0d cycles, required high", w, BUDGET);
        end
    endtask

    task automatic recover();
        i_rst_n = 1'b0;
        i_aad_valid = 1'b0;
        i_ct_valid = 1'b0;
        i_tag_valid = 1'b0;
        #1;
        pt_q.delete();
        vd_q.delete();
        aad_pending = 0;
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (o_aad_ready) rdy_aad_cnt++;
        if (o_ct_ready) begin
            rdy_ct_cnt++;
            if (aad_pending != 0) order_viol = 1'b1;
        end
        if (o_pt_valid) begin
            if (pt_q.size() == 0) chk("pt_unexpected", o_pt_valid, 1'b0);
            else chk("plaintext", o_plain_text, pt_q.pop_front());
        end
        if (o_done) begin
            t_done = $time;
            if (vd_q.size() == 0) chk("done_unexpected", o_done, 1'b0);
            else chk("verdict", {o_auth_ok, o_auth_fail}, vd_q.pop_front());
        end
    end

    task automatic run_vec(input int id, input vec_t t, input bit do_reset);
        int na, nc;
        bit ok;
        time t_start;
        logic [1:0] exp_v;
        na = nblk(t.asz);
        nc = nblk(t.csz);
        exp_v = t.exp_ok ? 2'b10 : 2'b01;
        @(negedge clk);
        i_hash_key = t.h;
        i_ek_j0 = t.e;
        i_aad_size = t.asz;
        i_ct_size = t.csz;
`ifdef GCM_DEC_TAG_TRUNC_EN
        tag_bits = t.tbits;
`endif
        aad_pending = na;
        rdy_aad_cnt = 0;
        rdy_ct_cnt = 0;
        order_viol = 1'b0;
        i_start = 1'b1;
        t_start = $time;
        @(negedge clk);
        i_start = 1'b0;
        chk($sformatf("v%0d_cleared", id), {o_auth_ok, o_auth_fail}, 2'b00);
        chk($sformatf("v%0d_busy", id), o_busy, 1'b1);
        for (int i = 0; i < na; i++) begin
            i_aad = pick(t.a0, t.a1, i);
            i_aad_valid = 1'b1;
            wait_ready(0, ok);
            if (!ok) begin recover(); return; end
            @(negedge clk);
            i_aad_valid = 1'b0;
            aad_pending--;
        end
        for (int i = 0; i < nc; i++) begin
            i_cipher_text = pick(t.c0, t.c1, i);
            i_keystream = pick(t.k0, t.k1, i);
            pt_q.push_back((i_cipher_text ^ i_keystream) & keep(i == nc - 1 ? int'(t.csz[57:63]) : 0));
            i_ct_valid = 1'b1;
            wait_ready(1, ok);
            if (!ok) begin recover(); return; end
            @(negedge clk);
            i_ct_valid = 1'b0;
        end
        if (do_reset) begin
            repeat (5) @(negedge clk);
            #2 i_rst_n = 1'b0;
            #1;
            chk($sformatf("v%0d_rst_flags", id), {o_aad_ready, o_ct_ready, o_tag_ready, o_pt_valid,
                o_busy, o_done, o_auth_ok, o_auth_fail}, 8'd0);
            chk($sformatf("v%0d_rst_plain", id), o_plain_text, 128'd0);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_rst_pt_left", id), pt_q.size(), 0);
            i_rst_n = 1'b1;
            return;
        end
        wait_ready(2, ok);
        if (!ok) begin recover(); return; end
        if (t.chk_s) chk($sformatf("v%0d_ghash", id), dut.s, t.s_exp);
        vd_q.push_back(exp_v);
        i_tag = t.tag;
        i_tag_valid = 1'b1;
        @(negedge clk);
        i_tag_valid = 1'b0;
        #1;
        for (int n = 0; vd_q.size() != 0 && n < 8; n++) begin
            @(negedge clk);
            #1;
        end
        if (vd_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL v%0d_done_timeout: no o_done within 8 cycles of tag handshake", id);
            vd_q.delete();
        end
        if (na == 0) chk($sformatf("v%0d_no_aad_ready", id), rdy_aad_cnt, 0);
        if (nc == 0) chk($sformatf("v%0d_no_ct_ready", id), rdy_ct_cnt, 0);
        if (na > 0 && nc > 0) chk($sformatf("v%0d_aad_before_ct", id), order_viol, 1'b0);
        if (na == 0 && nc == 0)
            chk($sformatf("v%0d_latency_ok", id), (t_done - t_start) <= time'((M + 3) * 10), 1'b1);
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d_held", id), {o_auth_ok, o_auth_fail, o_done, o_busy}, {exp_v, 2'b00});
        chk($sformatf("v%0d_pt_left", id), pt_q.size(), 0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t t, v1, v3;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_aad_valid = 1'b0;
        i_ct_valid = 1'b0;
        i_tag_valid = 1'b0;
        i_hash_key = '0;
        i_ek_j0 = '0;
        i_aad_size = '0;
        i_ct_size = '0;
        i_aad = '0;
        i_cipher_text = '0;
        i_keystream = '0;
        i_tag = '0;
`ifdef GCM_DEC_TAG_TRUNC_EN
        tag_bits = 8'd128;
`endif
        repeat (2) @(negedge clk);
        chk("reset_flags", {o_aad_ready, o_ct_ready, o_tag_ready, o_pt_valid, o_busy, o_done,
            o_auth_ok, o_auth_fail}, 8'd0);
        chk("reset_plain", o_plain_text, 128'd0);
        i_rst_n = 1'b1;

        vecs.push_back(mk(H0, E0, 64'd0, 64'd0, '0, '0, '0, '0, '0, '0, E0, 1'b1));
        v1 = mk(H0, E0, 64'd0, 64'd128, '0, '0, C1, '0, C1, '0, T1, 1'b1);
        v1.chk_s = 1'b1;
        v1.s_exp = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
        vecs.push_back(v1);
        vecs.push_back(mk(H0, E0, 64'd0, 64'd128, '0, '0, C1, '0, C1, '0, T1 ^ 128'd1, 1'b0));
        v3 = mk(H0, E0, 64'd128, 64'd100, '0, '0, 128'h42831ec2217774244b7221b784d0d49c, '0,
                128'h0123456789abcdeffedcba9876543210, '0, '0, 1'b1);
        v3.tag = model_tag(v3);
        vecs.push_back(v3);
        t = mk(128'hb83b533708bf535d0aa6e52980d53b78, 128'h3247184b3c4f69a44dbcd22887bbb418,
               64'd160, 64'd200, 128'hfeedfacedeadbeeffeedfacedeadbeef, 128'habaddad2ffffffffffffffffffffffff,
               128'h42831ec2217774244b7221b784d0d49c, 128'he3aa212f2c02a4e035c17e2329aca12e,
               128'h0f0e0d0c0b0a09080706050403020100, 128'h11223344556677889900aabbccddeeff, '0, 1'b1);
        t.tag = model_tag(t);
        vecs.push_back(t);
        t.tag = t.tag ^ {1'b1, 127'd0};
        t.exp_ok = 1'b0;
        vecs.push_back(t);
        t = mk(H0, E0, 64'd64, 64'd0, 128'hd9313225f88406e5a55909c5aff5269a, '0, '0, '0, '0, '0, '0, 1'b1);
        t.tag = model_tag(t);
        vecs.push_back(t);
`ifdef GCM_DEC_TAG_TRUNC_EN
        t = v1;
        t.chk_s = 1'b0;
        t.tag = T1 ^ 128'hffffffff;
        t.tbits = 8'd96;
        vecs.push_back(t);
        t.tbits = 8'd100;
        t.exp_ok = 1'b0;
        vecs.push_back(t);
`endif
        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i], 1'b0);

        run_vec(100, v3, 1'b1);
        run_vec(101, v1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
